// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 32x32 unsigned multiplier.
package mul_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = 6;

  // Bit s set means STEP=s is a supported retire width.
  localparam logic [7:0] STEP_LEGAL_MASK = 8'b0001_0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit step_is_legal(input int unsigned s);
    return (s < 8) && STEP_LEGAL_MASK[s[2:0]];
  endfunction

endpackage

// File: rtl/mul_step.sv
// One add-and-shift iteration: add a*m at bit W of the accumulator, then shift right by STEP.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [PW+STEP-1:0] acc_i,
  input  logic [W-1:0]       a_i,
  input  logic [STEP-1:0]    m_i,
  output logic [PW+STEP-1:0] acc_o
);

  localparam int unsigned AW = PW + STEP;

  logic [W+STEP-1:0] part;
  logic [AW-1:0]     sum;

  // Terms enter at bit W and only move down, so the low product bits are never shifted out.
  always_comb begin
    part  = (W+STEP)'(a_i) * (W+STEP)'(m_i);
    sum   = acc_i + {part, {W{1'b0}}};
    acc_o = sum >> STEP;
  end

endmodule

// File: rtl/mul32_iter.sv
// Iterative 32x32 -> 64 unsigned multiplier retiring STEP multiplier bits per cycle,
// with valid/ready handshakes on operands and product.
module mul32_iter
  import mul_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p
);

  localparam int unsigned AW      = PW + STEP;
  localparam int unsigned N_STEPS = W / STEP;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - 1);

  if (!step_is_legal(STEP)) begin : g_bad_step
    $error("mul32_iter: STEP must be 1, 2 or 4");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    step_acc;

  mul_step #(.STEP(STEP)) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .m_i   (b_q[STEP-1:0]),
    .acc_o (step_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operands are sampled only on the accept edge, so later input changes are ignored.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    if (state_q == IDLE && in_valid) begin
      cnt_d = '0;
      acc_d = '0;
      a_d   = a;
      b_d   = b;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = step_acc;
      b_d   = b_q >> STEP;
    end
  end

  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q[PW-1:0];

endmodule

// File: tb/tb_mul32_iter.sv
// Directed bench for mul32_iter: STEP=1 and STEP=4 instances share stimulus, results go through a scoreboard.
module tb_mul32_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready1, out_valid1;
  logic        in_ready4, out_valid4;
  logic [63:0] p1, p4;

  int          n_checks;
  int          n_fail;
  logic [63:0] sb[$];
  logic [63:0] last_p;

  mul32_iter #(.STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .p(p1)
  );

  mul32_iter #(.STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .p(p4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input bit scramble, input int hold);
    logic [63:0] exp;
    int lat1, lat4, t;
    @(negedge clk);
    check("in_ready1 idle", 64'(in_ready1), 64'd1);
    check("in_ready4 idle", 64'(in_ready4), 64'd1);
    a = ai;
    b = bi;
    in_valid = 1'b1;
    sb.push_back(64'(ai) * 64'(bi));
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready1 busy", 64'(in_ready1), 64'd0);
    lat1 = -1;
    lat4 = -1;
    t = 0;
    while (lat1 < 0 && t < 100) begin
      if (out_valid4 && lat4 < 0) lat4 = t;
      if (out_valid1) lat1 = t;
      else begin
        if (scramble) begin
          a = $urandom;
          b = $urandom;
          in_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        t++;
      end
    end
    in_valid = 1'b0;
    check("latency STEP=1", 64'(lat1), 64'd32);
    check("latency STEP=4", 64'(lat4), 64'd8);
    exp = sb.pop_front();
    check("p STEP=1", p1, exp);
    check("p STEP=4", p4, exp);
    last_p = p1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held out_valid1", 64'(out_valid1), 64'd1);
      check("held p1", p1, exp);
      check("held out_valid4", 64'(out_valid4), 64'd1);
      check("held p4", p4, exp);
    end
    // in_valid held high across the product handshake must not start a new operation
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid1 after hs", 64'(out_valid1), 64'd0);
    check("in_ready1 after hs", 64'(in_ready1), 64'd1);
    check("out_valid4 after hs", 64'(out_valid4), 64'd0);
    check("in_ready4 after hs", 64'(in_ready4), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          seen;
    n_checks  = 0;
    n_fail    = 0;
    last_p    = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h1234_5678;
    b         = 32'h9abc_def0;
    #1;
    check("reset in_ready1", 64'(in_ready1), 64'd1);
    check("reset out_valid1", 64'(out_valid1), 64'd0);
    check("reset p1", p1, 64'd0);
    check("reset in_ready4", 64'(in_ready4), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 1'b0, 0);
    check("directed 3*5", last_p, 64'd15);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("max operands", last_p, 64'hFFFF_FFFE_0000_0001);

    run_op(32'd0, 32'd123, 1'b0, 0);
    check("zero operand", last_p, 64'd0);

    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 10);

    run_op(32'hCAFE_F00D, 32'h8765_4321, 1'b1, 0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      run_op(ra, rb, 1'b0, 0);
      check("roundtrip quotient", last_p / 64'(rb), 64'(ra));
      check("roundtrip remainder", last_p % 64'(rb), 64'd0);
    end

    // Abort an operation after 17 steps; it must never be presented
    @(negedge clk);
    a = 32'h0F0F_0F0F;
    b = 32'hF0F0_F0F0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_valid1", 64'(out_valid1), 64'd0);
    check("abort in_ready1", 64'(in_ready1), 64'd1);
    check("abort p1", p1, 64'd0);
    check("abort out_valid4", 64'(out_valid4), 64'd0);
    check("abort p4", p4, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) seen = 1'b1;
    end
    check("aborted never valid", 64'(seen), 64'd0);

    run_op(32'd7, 32'd9, 1'b0, 0);
    check("after abort 7*9", last_p, 64'd63);
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul32_iter.md
MUL32_ITER -- requirements
Module: mul32_iter

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning multiplier bits retired per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, 32 bits: unsigned multiplicand.
REQ-007 SHALL have port b, input, 32 bits: unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit: product present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-010 SHALL have port p, output, 64 bits: product a*b, unsigned, exact, no truncation.

Function
REQ-011 SHALL implement three states: IDLE, BUSY, DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in BUSY and DONE, in_ready SHALL be 0.
REQ-013 At an edge with IDLE, in_valid=1: SHALL capture a and b, clear the accumulator, set the step counter to 0 and go to BUSY.
REQ-014 In BUSY, each edge SHALL add a times the low STEP bits of the remaining multiplier into the accumulator, shift by STEP, and increment the counter.
REQ-015 The accumulator SHALL be 64+STEP bits wide internally so that no carry is lost.
REQ-016 BUSY SHALL last exactly 32/STEP cycles; the edge that completes the final step SHALL go to DONE.
REQ-017 out_valid SHALL be 1 only in DONE, i.e. from 32/STEP cycles after the accept edge.
REQ-018 p SHALL hold the full product and stay stable throughout DONE.
REQ-019 At an edge with DONE, out_ready=1: SHALL go to IDLE.
REQ-020 in_ready SHALL rise in the following cycle; no operands are accepted on the same edge as the product handshake.
REQ-021 With out_ready held 0, SHALL remain in DONE indefinitely with p unchanged.
REQ-022 Changes on a, b or in_valid during BUSY or DONE SHALL have no effect.
REQ-023 Operands of 0, and 32'hFFFFFFFF × 32'hFFFFFFFF = 64'hFFFFFFFE00000001, SHALL take the same latency; there is no early termination.
REQ-024 p outside DONE is don't-care to consumers but SHALL be deterministic (the accumulator value).

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state=IDLE, counter=0, accumulator=0 and operand registers=0.
REQ-026 Under reset, outputs SHALL be in_ready=1, out_valid=0 and p=0.
REQ-027 Reset asserted mid-BUSY or in DONE SHALL abort the operation; the result SHALL never be presented.
REQ-028 After rst falls, the first edge with in_valid=1 SHALL be accepted.

Structure
REQ-029 A shared package mul_pkg SHALL hold:
- the state enum (IDLE/BUSY/DONE);
- width constant W=32;
- the legal-STEP check constant.
REQ-030 A combinational sub-module mul_step SHALL perform one STEP-bit add-and-shift iteration; mul32_iter SHALL instantiate it once.
REQ-031 The design SHALL contain no combinational path from in_valid or out_ready to any output.

Verification
REQ-032 Scenario, directed product: a=3, b=5, STEP=1 -> out_valid rises 32 cycles after accept, p=64'd15.
REQ-033 Scenario, maximum operands: a=b=32'hFFFFFFFF -> p=64'hFFFFFFFE00000001; with STEP=4, latency is 8 cycles.
REQ-034 Scenario, backpressure: out_ready=0 for 10 cycles in DONE -> p and out_valid held; then out_ready=1 -> one handshake, followed by in_ready=1 the next cycle.
REQ-035 Scenario, reset mid-operation: rst pulsed at BUSY step 17 -> out_valid never rises for that operation; next operation a=7, b=9 -> p=63.
REQ-036 Scenario, round trip with div32: random a and nonzero b; feed x=p, d=b into div32 -> q=a, r=0; also a=0, b=123 -> p=0.
REQ-037 Scenario, operand isolation: a and b changed every cycle during BUSY -> the result equals the product of the operands captured at the accept edge.
